// File: rtl/lfsr_bank.sv
// ---------------------------------------------------------------------------
// lfsr_bank
//
// Multi-channel pseudo-random source for the neuron array. NCH independent
// XNOR Fibonacci LFSRs of DSIZE bits share one seed-programming port. Each
// channel runs a small two-state FSM:
//   WARM  : the LFSR free-runs every cycle (read strobes ignored) while a
//           counter loaded with WARMUP counts down; vld is low.
//   READY : vld is high and the LFSR advances only on its read strobe.
// A reset or a seed write restarts the channel in WARM (or directly in READY
// when WARMUP is 0), so freshly seeded values are decorrelated before use.
//
// The XNOR form has a single lock-up state, all ones. A seed write of all
// ones is rejected (the channel's reset seed is loaded instead and the sticky
// lockup flag is raised), and an advance from all ones reloads the reset seed
// and raises the same flag.
//
// Parameters
//   DSIZE       LFSR width, 3..32
//   NCH         number of channels, >= 1
//   SEED_BASE   reset seed of channel 0
//   SEED_STRIDE increment of the reset seed from one channel to the next
//   WARMUP      free-running advances after reset/seed before vld; 0 allowed
//
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   rd_rand_i    per-channel consume/advance strobe (honoured in READY)
//   seed_wr_i    seed write strobe
//   seed_ch_i    target channel of the seed write (>= NCH: ignored)
//   seed_dat_i   seed value
//   lfsr_dat_o   channel c state at bits [c*DSIZE +: DSIZE]
//   lfsr_vld_o   channel c is in READY
//   lockup_o     sticky per channel: an all-ones state/seed was replaced
// ---------------------------------------------------------------------------
module lfsr_bank #(
    parameter int          DSIZE       = 16,
    parameter int          NCH         = 4,
    parameter int unsigned SEED_BASE   = 896,
    parameter int unsigned SEED_STRIDE = 1,
    parameter int          WARMUP      = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [NCH-1:0]                           rd_rand_i,
    input  logic                                     seed_wr_i,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] seed_ch_i,
    input  logic [DSIZE-1:0]                         seed_dat_i,
    output logic [NCH*DSIZE-1:0]                     lfsr_dat_o,
    output logic [NCH-1:0]                           lfsr_vld_o,
    output logic [NCH-1:0]                           lockup_o
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    // Parameter legality is checked at elaboration time.
    if (DSIZE < 3 || DSIZE > 32) begin : g_bad_dsize
        $error("lfsr_bank: DSIZE must be in 3..32");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("lfsr_bank: NCH must be at least 1");
    end
    if (WARMUP < 0) begin : g_bad_warmup
        $error("lfsr_bank: WARMUP must not be negative");
    end

    typedef enum logic {
        ST_WARM  = 1'b0,
        ST_READY = 1'b1
    } ch_state_e;

    localparam ch_state_e      ST_INIT  = (WARMUP == 0) ? ST_READY : ST_WARM;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP);

    // One-hot mask for a tap numbered 1..32 (tap 1 is the LSB).
    function automatic logic [31:0] tap_bit(input int n);
        return 32'(1) << (n - 1);
    endfunction

    // Maximal-length XNOR tap sets, one entry per supported width.
    function automatic logic [31:0] tap_table(input int width);
        logic [31:0] m;
        m = '0;
        case (width)
            3:       m = tap_bit(3)  | tap_bit(2);
            4:       m = tap_bit(4)  | tap_bit(3);
            5:       m = tap_bit(5)  | tap_bit(3);
            6:       m = tap_bit(6)  | tap_bit(5);
            7:       m = tap_bit(7)  | tap_bit(6);
            8:       m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:       m = tap_bit(9)  | tap_bit(5);
            10:      m = tap_bit(10) | tap_bit(7);
            11:      m = tap_bit(11) | tap_bit(9);
            12:      m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13:      m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14:      m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15:      m = tap_bit(15) | tap_bit(14);
            16:      m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17:      m = tap_bit(17) | tap_bit(14);
            18:      m = tap_bit(18) | tap_bit(11);
            19:      m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20:      m = tap_bit(20) | tap_bit(17);
            21:      m = tap_bit(21) | tap_bit(19);
            22:      m = tap_bit(22) | tap_bit(21);
            23:      m = tap_bit(23) | tap_bit(18);
            24:      m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25:      m = tap_bit(25) | tap_bit(22);
            26:      m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27:      m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28:      m = tap_bit(28) | tap_bit(25);
            29:      m = tap_bit(29) | tap_bit(27);
            30:      m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31:      m = tap_bit(31) | tap_bit(28);
            32:      m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [DSIZE-1:0] TAPS = DSIZE'(tap_table(DSIZE));

    // One Fibonacci step: shift towards the MSB, XNOR of the taps enters at
    // bit 1.
    function automatic logic [DSIZE-1:0] lfsr_step(input logic [DSIZE-1:0] s);
        logic fb;
        fb = ~(^(s & TAPS));
        return {s[DSIZE-2:0], fb};
    endfunction

    // Reset seed of a channel, wrapped to DSIZE bits. All ones would lock the
    // XNOR register, so it is replaced by zero.
    function automatic logic [DSIZE-1:0] reset_seed(input int ch);
        logic [63:0]      sum;
        logic [DSIZE-1:0] seed;
        sum  = 64'(SEED_BASE) + 64'(ch) * 64'(SEED_STRIDE);
        seed = DSIZE'(sum);
        if (&seed) begin
            seed = '0;
        end
        return seed;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [DSIZE-1:0] RST_SEED = reset_seed(c);

        ch_state_e        state_q, state_d;
        logic [DSIZE-1:0] lfsr_q, lfsr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lock_q, lock_d;
        logic             seed_hit;
        logic             advance;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign seed_hit = seed_wr_i && (seed_ch_i == CH_W'(c));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_q <= ST_INIT;
                lfsr_q  <= RST_SEED;
                cnt_q   <= CNT_INIT;
                lock_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                lfsr_q  <= lfsr_d;
                cnt_q   <= cnt_d;
                lock_q  <= lock_d;
            end
        end

        always_comb begin
            state_d = state_q;
            lfsr_d  = lfsr_q;
            cnt_d   = cnt_q;
            lock_d  = lock_q;
            advance = 1'b0;

            case (state_q)
                ST_WARM: begin
                    advance = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    // This cycle performs the last warm-up advance.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    advance = rd_rand_i[c];
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase

            if (advance) begin
                if (&lfsr_q) begin
                    lfsr_d = RST_SEED;
                    lock_d = 1'b1;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end

            // A seed write overrides any advance on the same cycle.
            if (seed_hit) begin
                state_d = ST_INIT;
                cnt_d   = CNT_INIT;
                if (&seed_dat_i) begin
                    lfsr_d = RST_SEED;
                    lock_d = 1'b1;
                end else begin
                    lfsr_d = seed_dat_i;
                    lock_d = 1'b0;
                end
            end
        end

        assign lfsr_dat_o[c*DSIZE +: DSIZE] = lfsr_q;
        assign lfsr_vld_o[c]                = (state_q == ST_READY);
        assign lockup_o[c]                  = lock_q;
    end

endmodule

// File: tb/tb_lfsr_bank.sv
module tb_lfsr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DSIZE=16, NCH=4, WARMUP=0
    logic        a_rst_n;
    logic [3:0]  a_rd;
    logic        a_wr;
    logic [1:0]  a_ch;
    logic [15:0] a_sd;
    logic [63:0] a_dat;
    logic [3:0]  a_vld;
    logic [3:0]  a_lock;

    // DSIZE=16, NCH=3, WARMUP=8
    logic        b_rst_n;
    logic [2:0]  b_rd;
    logic        b_wr;
    logic [1:0]  b_ch;
    logic [15:0] b_sd;
    logic [47:0] b_dat;
    logic [2:0]  b_vld;
    logic [2:0]  b_lock;

    // DSIZE=4, NCH=1, WARMUP=0
    logic        c_rst_n;
    logic        c_rd;
    logic        c_wr;
    logic        c_ch;
    logic [3:0]  c_sd;
    logic [3:0]  c_dat;
    logic        c_vld;
    logic        c_lock;

    // Width sweep 3..32
    logic        sw_rst_n;
    logic        sw_rd;
    logic        sw_run = 1'b0;
    int          sw_steps;
    int          sw_rep [3:32];
    logic        sw_bad [3:32];

    lfsr_bank #(.DSIZE(16), .NCH(4), .WARMUP(0)) u_dut_a (
        .clk_i(clk), .reset_n_i(a_rst_n), .rd_rand_i(a_rd), .seed_wr_i(a_wr),
        .seed_ch_i(a_ch), .seed_dat_i(a_sd), .lfsr_dat_o(a_dat),
        .lfsr_vld_o(a_vld), .lockup_o(a_lock)
    );

    lfsr_bank #(.DSIZE(16), .NCH(3), .WARMUP(8)) u_dut_b (
        .clk_i(clk), .reset_n_i(b_rst_n), .rd_rand_i(b_rd), .seed_wr_i(b_wr),
        .seed_ch_i(b_ch), .seed_dat_i(b_sd), .lfsr_dat_o(b_dat),
        .lfsr_vld_o(b_vld), .lockup_o(b_lock)
    );

    lfsr_bank #(.DSIZE(4), .NCH(1), .WARMUP(0)) u_dut_c (
        .clk_i(clk), .reset_n_i(c_rst_n), .rd_rand_i(c_rd), .seed_wr_i(c_wr),
        .seed_ch_i(c_ch), .seed_dat_i(c_sd), .lfsr_dat_o(c_dat),
        .lfsr_vld_o(c_vld), .lockup_o(c_lock)
    );

    always @(negedge clk) begin
        if (!sw_run) sw_steps <= 0;
        else         sw_steps <= sw_steps + 1;
    end

    for (genvar w = 3; w <= 32; w++) begin : g_sw
        logic [w-1:0] dat;
        logic [w-1:0] start;
        logic         vld;
        logic         lock;
        int           rep;
        logic         bad;

        lfsr_bank #(.DSIZE(w), .NCH(1), .WARMUP(0)) u_sw (
            .clk_i(clk), .reset_n_i(sw_rst_n), .rd_rand_i(sw_rd), .seed_wr_i(1'b0),
            .seed_ch_i(1'b0), .seed_dat_i({w{1'b0}}), .lfsr_dat_o(dat),
            .lfsr_vld_o(vld), .lockup_o(lock)
        );

        // rep records the number of advances at which the start state first recurs.
        always @(negedge clk) begin
            if (!sw_run) begin
                rep   <= 0;
                bad   <= 1'b0;
                start <= dat;
            end else begin
                if (rep == 0 && dat == start) rep <= sw_steps + 1;
                if ((&dat) || lock || !vld) bad <= 1'b1;
            end
        end

        assign sw_rep[w] = rep;
        assign sw_bad[w] = bad;
    end

    initial begin
        sw_rst_n = 1'b0;
        sw_rd    = 1'b1;
        repeat (3) @(posedge clk);
        #1 sw_rst_n = 1'b1;
        @(posedge clk);
        #1 sw_run = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  rd;
        logic        wr;
        logic [1:0]  ch;
        logic [15:0] sd;
        logic [63:0] dat;
        logic [3:0]  lock;
    } vec_t;

    vec_t        tbl  [15];
    logic [15:0] wexp [8];
    logic [3:0]  cseq [15];
    int          guard;

    initial begin
        //           rd       wr    ch    seed      {ch3,ch2,ch1,ch0}         lock
        tbl[0]  = '{4'b0000, 1'b0, 2'd0, 16'h0000, 64'h0383_0382_0381_0380, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b0, 2'd0, 16'h0000, 64'h0383_0382_0381_0701, 4'b0000};
        tbl[2]  = '{4'b1001, 1'b0, 2'd0, 16'h0000, 64'h0707_0382_0381_0E03, 4'b0000};
        tbl[3]  = '{4'b1111, 1'b0, 2'd0, 16'h0000, 64'h0E0F_0705_0703_1C07, 4'b0000};
        tbl[4]  = '{4'b0000, 1'b1, 2'd2, 16'hFFFF, 64'h0E0F_0382_0703_1C07, 4'b0100};
        tbl[5]  = '{4'b0000, 1'b1, 2'd2, 16'h1234, 64'h0E0F_1234_0703_1C07, 4'b0000};
        tbl[6]  = '{4'b0010, 1'b1, 2'd1, 16'hBEEF, 64'h0E0F_1234_BEEF_1C07, 4'b0000};
        tbl[7]  = '{4'b0001, 1'b0, 2'd0, 16'h0000, 64'h0E0F_1234_BEEF_380E, 4'b0000};
        tbl[8]  = '{4'b1000, 1'b1, 2'd3, 16'h0000, 64'h0000_1234_BEEF_380E, 4'b0000};
        tbl[9]  = '{4'b1000, 1'b0, 2'd0, 16'h0000, 64'h0001_1234_BEEF_380E, 4'b0000};
        tbl[10] = '{4'b0100, 1'b0, 2'd0, 16'h0000, 64'h0001_2468_BEEF_380E, 4'b0000};
        tbl[11] = '{4'b0001, 1'b1, 2'd0, 16'hFFFF, 64'h0001_2468_BEEF_0380, 4'b0001};
        tbl[12] = '{4'b0001, 1'b0, 2'd0, 16'h0000, 64'h0001_2468_BEEF_0701, 4'b0001};
        tbl[13] = '{4'b0000, 1'b1, 2'd0, 16'h8000, 64'h0001_2468_BEEF_8000, 4'b0000};
        tbl[14] = '{4'b0001, 1'b0, 2'd0, 16'h0000, 64'h0001_2468_BEEF_0000, 4'b0000};

        wexp = '{16'h0701, 16'h0E03, 16'h1C07, 16'h380E,
                 16'h701D, 16'hE03A, 16'hC074, 16'h80E9};
        cseq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

        a_rst_n = 1'b0; a_rd = '0; a_wr = 1'b0; a_ch = '0; a_sd = '0;
        b_rst_n = 1'b0; b_rd = '0; b_wr = 1'b0; b_ch = '0; b_sd = '0;
        c_rst_n = 1'b0; c_rd = 1'b0; c_wr = 1'b0; c_ch = 1'b0; c_sd = '0;

        // Values held during reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_dat",  a_dat,  64'h0383_0382_0381_0380);
        check("rst_a_vld",  a_vld,  4'hF);
        check("rst_a_lock", a_lock, 4'h0);
        check("rst_b_dat",  b_dat,  48'h0382_0381_0380);
        check("rst_b_vld",  b_vld,  3'b000);
        check("rst_b_lock", b_lock, 3'b000);
        check("rst_c_dat",  c_dat,  4'h0);

        // Table-driven read/seed vectors on the WARMUP=0 bank
        a_rst_n = 1'b1;
        c_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            a_rd = tbl[i].rd;
            a_wr = tbl[i].wr;
            a_ch = tbl[i].ch;
            a_sd = tbl[i].sd;
            tick();
            check($sformatf("tbl%0d_dat", i),  a_dat,  tbl[i].dat);
            check($sformatf("tbl%0d_lock", i), a_lock, tbl[i].lock);
            check($sformatf("tbl%0d_vld", i),  a_vld,  4'hF);
        end
        a_rd = '0;
        a_wr = 1'b0;

        // Warm-up after reset: rd ignored, vld low for 8 advances
        b_rd    = 3'b111;
        b_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("warm%0d_vld", k), b_vld, (k == 7) ? 3'b111 : 3'b000);
            check($sformatf("warm%0d_ch0", k), b_dat[15:0], wexp[k]);
        end
        b_rd = '0;
        tick();
        tick();
        check("hold_ch0", b_dat[15:0], 16'h80E9);
        check("hold_vld", b_vld, 3'b111);
        b_rd = 3'b001;
        tick();
        b_rd = '0;
        check("rd_ch0", b_dat[15:0], 16'h01D3);

        // All-ones seed rejected, then a good seed clears the flag
        b_wr = 1'b1; b_ch = 2'd2; b_sd = 16'hFFFF;
        tick();
        b_wr = 1'b0;
        check("ff_ch2",   b_dat[47:32], 16'h0382);
        check("ff_lock",  b_lock, 3'b100);
        check("ff_vld",   b_vld, 3'b011);
        check("ff_ch0",   b_dat[15:0], 16'h01D3);
        b_wr = 1'b1; b_ch = 2'd2; b_sd = 16'h1234;
        tick();
        b_wr = 1'b0;
        check("sd_ch2",   b_dat[47:32], 16'h1234);
        check("sd_lock",  b_lock, 3'b000);
        check("sd_vld",   b_vld, 3'b011);
        tick();
        check("sd_warm1", b_dat[47:32], 16'h2468);
        repeat (6) tick();
        check("sd_vld7",  b_vld, 3'b011);
        tick();
        check("sd_vld8",  b_vld, 3'b111);
        check("sd_warm8", b_dat[47:32], 16'h3419);

        // Seed to channel NCH is dropped
        b_wr = 1'b1; b_ch = 2'd3; b_sd = 16'h5555;
        tick();
        b_wr = 1'b0;
        check("bad_ch_ch0",  b_dat[15:0], 16'h01D3);
        check("bad_ch_ch2",  b_dat[47:32], 16'h3419);
        check("bad_ch_vld",  b_vld, 3'b111);
        check("bad_ch_lock", b_lock, 3'b000);

        // Asynchronous reset in the middle of a warm-up
        b_wr = 1'b1; b_ch = 2'd0; b_sd = 16'hFFFF;
        tick();
        b_wr = 1'b0;
        check("mid_ch0",  b_dat[15:0], 16'h0380);
        check("mid_lock", b_lock, 3'b001);
        check("mid_vld",  b_vld, 3'b110);
        tick();
        tick();
        #2 b_rst_n = 1'b0;
        #1;
        check("arst_dat",  b_dat, 48'h0382_0381_0380);
        check("arst_vld",  b_vld, 3'b000);
        check("arst_lock", b_lock, 3'b000);
        tick();
        b_rst_n = 1'b1;
        repeat (8) tick();
        check("rewarm_vld", b_vld, 3'b111);
        check("rewarm_ch0", b_dat[15:0], 16'h80E9);

        // 4-bit sequence from seed 0000, rd held high
        c_wr = 1'b1; c_ch = 1'b0; c_sd = 4'h0;
        tick();
        c_wr = 1'b0;
        check("c_seed", c_dat, 4'h0);
        c_rd = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("c_seq%0d", k), c_dat, cseq[k % 15]);
        end
        c_rd = 1'b0;
        check("c_lock", c_lock, 1'b0);
        check("c_vld",  c_vld, 1'b1);

        // Width sweep results
        guard = 0;
        while (sw_steps < 32770 && guard < 40000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("sweep_budget", (sw_steps >= 32770), 1'b1);
        for (int w = 3; w <= 32; w++) begin
            check($sformatf("period_w%0d", w), sw_rep[w], (w <= 15) ? ((1 << w) - 1) : 0);
            check($sformatf("clean_w%0d", w),  sw_bad[w], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
